count_seq_checker: RTL
======================

Name: count_seq_checker

Overview:
- Downstream consumer of the free-running up-counter output; samples the counter value each valid cycle.
- Checks that the sequence increments by exactly 1 modulo 2^WIDTH.
- Acquires and maintains lock, counts wrap-arounds, and flags and counts sequence errors.
- Acts as the on-chip health monitor for the counter stage, feeding status to test and debug logic.

Parameters:
- WIDTH, 4: width of the sampled counter value.
- LOCK_CNT, 2: consecutive correct increments required to declare lock (legal range 1–15).
- WRAP_W, 8: width of the wrap counter.
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  rising-edge clock shared with the upstream counter.
- reset  in  1  synchronous, active-low reset; the design is in reset while reset==0.
- count_in  in  WIDTH  counter value from the upstream stage.
- count_valid  in  1  count_in is meaningful this cycle; samples with count_valid==0 are ignored.
- clear  in  1  synchronous clear of wrap_count and err_count only.
- locked  out  1  sequence lock status.
- err_pulse  out  1  one-cycle pulse on a sequence error while locked.
- err_count  out  ERR_W  saturating count of locked-state errors.
- wrap_count  out  WRAP_W  saturating count of locked-state wraps (2^WIDTH-1 -> 0).
- expected  out  WIDTH  next value expected (prev+1 mod 2^WIDTH); 0 when no previous sample exists.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Outputs: locked=0, err_pulse=0, err_count=0, wrap_count=0, expected=0.
  - Internal: prev=0, has_prev=0, run=0, state=UNLOCKED.
  - Applies mid-operation too; reset has priority over every other input.
- All outputs are registered. A sample accepted at edge N is reflected in the outputs after edge N, i.e. visible in cycle N+1. Latency is 1 cycle.
- Accepted sample: count_valid==1 and reset==1. Accepted samples need not be on consecutive cycles; gaps (count_valid==0) hold all state and drive err_pulse=0.
- match = has_prev && (count_in == prev+1 mod 2^WIDTH). On every accepted sample: prev<=count_in, has_prev<=1.
- FSM states: UNLOCKED, LOCKED.
  - UNLOCKED, accepted sample:
    - match: run<=run+1.
    - no match: run<=0.
    - If match and run+1==LOCK_CNT: state<=LOCKED, run<=0.
    - Mismatches in UNLOCKED raise no err_pulse and leave err_count unchanged.
    - Wraps in UNLOCKED are not counted.
  - LOCKED, accepted sample:
    - match: stay LOCKED.
    - match and prev==2^WIDTH-1 (so count_in==0): wrap_count increments, saturating at all-ones.
    - no match: err_pulse=1 for exactly one cycle; err_count increments, saturating at all-ones; state<=UNLOCKED; run<=0. The erroneous sample becomes prev, so relock starts from it.
- locked==1 exactly when state==LOCKED.
- expected: prev+1 mod 2^WIDTH when has_prev, else 0.
- clear (with reset==1): err_count and wrap_count go to 0 at that edge.
  - clear has priority over a same-edge increment, so the counters read 0.
  - The FSM, err_pulse, prev and run behave as if clear were 0.
- Arithmetic: WIDTH-bit compare is modulo 2^WIDTH; counter saturation is done without overflow.

Test Plan:
1. Basic lock and wrap (defaults):
   - Stimulus: reset released, then count_in 0,1,2,…,15,0,1 with count_valid=1 every cycle.
   - Required: locked rises the cycle after sample 2; wrap_count=1 after the 15->0 sample; err_count=0; err_pulse never high; expected tracks the next value.
2. Skip error and relock:
   - Stimulus: while locked, sequence 3,5,6,7.
   - Required: err_pulse=1 for one cycle after the 5; err_count=1; locked=0; locked=1 again after the 7.
3. Valid gaps:
   - Stimulus: locked at 3; count_valid=0 for 3 cycles with count_in=9; then a valid 4.
   - Required: no error; locked stays 1; expected=4 throughout the gap.
4. Saturation:
   - Stimulus: ERR_W=2; force 4 locked-state errors, relocking between each.
   - Required: err_count reads 1,2,3,3.
5. Clear vs error collision:
   - Stimulus: clear=1 on the same edge as a locked mismatch with err_count=2.
   - Required: err_count=0; err_pulse=1; locked=0.
6. Reset mid-operation:
   - Stimulus: locked with wrap_count=5; reset=0 for one cycle; resume the sequence 7,8,9.
   - Required: all outputs 0 after the reset edge; locked=1 again after the 9 (first sample 7 only seeds prev).

Source files
------------

// File: rtl/count_seq_if.sv
// Bundle between the counter stage and its sequence checker: sampled value and
// qualifiers toward the checker, lock/error/wrap status back from it.
interface count_seq_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 8
);
    logic [WIDTH-1:0]  count_in;
    logic              count_valid;
    logic              clear;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;
    logic [WIDTH-1:0]  expected;

    modport master (
        output count_in, count_valid, clear,
        input  locked, err_pulse, err_count, wrap_count, expected
    );

    modport slave (
        input  count_in, count_valid, clear,
        output locked, err_pulse, err_count, wrap_count, expected
    );
endinterface

// File: rtl/count_seq_checker.sv
// Health monitor for the free-running up-counter: locks onto a +1 mod 2^WIDTH
// sequence, then counts wraps and flags/counts sequence errors while locked.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8
) (
    input  logic          clk,
    input  logic          reset,
    count_seq_if.slave    bus
);
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // One spare bit so the run+1 comparison never wraps for LOCK_CNT up to 15.
    localparam int              RUN_W      = 4;
    localparam logic [RUN_W:0]  LOCK_CNT_V = (RUN_W + 1)'(LOCK_CNT);

    state_t             state, state_d;
    logic [WIDTH-1:0]   prev, prev_d;
    logic               has_prev, has_prev_d;
    logic [RUN_W-1:0]   run, run_d;
    logic               err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [WRAP_W-1:0]  wrap_q, wrap_d;
    logic [WIDTH-1:0]   expected_q, expected_d;

    logic [WIDTH-1:0]   prev_inc;
    logic [RUN_W:0]     run_inc;
    logic               match;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        prev_inc    = prev + WIDTH'(1);
        run_inc     = {1'b0, run} + (RUN_W + 1)'(1);
        match       = has_prev && (bus.count_in == prev_inc);

        state_d     = state;
        prev_d      = prev;
        has_prev_d  = has_prev;
        run_d       = run;
        err_pulse_d = 1'b0;
        err_d       = err_q;
        wrap_d      = wrap_q;

        if (bus.count_valid) begin
            prev_d     = bus.count_in;
            has_prev_d = 1'b1;
            unique case (state)
                UNLOCKED: begin
                    if (!match) begin
                        run_d = '0;
                    end else if (run_inc == LOCK_CNT_V) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc[RUN_W-1:0];
                    end
                end
                LOCKED: begin
                    if (match) begin
                        if (prev == '1 && wrap_q != '1) wrap_d = wrap_q + WRAP_W'(1);
                    end else begin
                        // The erroneous sample already became prev, so relock starts from it.
                        err_pulse_d = 1'b1;
                        state_d     = UNLOCKED;
                        run_d       = '0;
                        if (err_q != '1) err_d = err_q + ERR_W'(1);
                    end
                end
            endcase
        end

        // Clear wins over a same-edge increment; the FSM is unaffected.
        if (bus.clear) begin
            err_d  = '0;
            wrap_d = '0;
        end

        expected_d = has_prev_d ? (prev_d + WIDTH'(1)) : '0;
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= UNLOCKED;
            prev        <= '0;
            has_prev    <= 1'b0;
            run         <= '0;
            err_pulse_q <= 1'b0;
            err_q       <= '0;
            wrap_q      <= '0;
            expected_q  <= '0;
        end else begin
            state       <= state_d;
            prev        <= prev_d;
            has_prev    <= has_prev_d;
            run         <= run_d;
            err_pulse_q <= err_pulse_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
            expected_q  <= expected_d;
        end
    end

    assign bus.locked     = (state == LOCKED);
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_count  = err_q;
    assign bus.wrap_count = wrap_q;
    assign bus.expected   = expected_q;
endmodule
